// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the core instruction sequencer:
//   - bit positions of every field in the 34-bit core instruction word
//   - the IDLE instruction word (both SRAMs disabled, nothing strobed)
//   - the sequencer state enum
//   - a small compile-time max helper used to size counters
// ---------------------------------------------------------------------------
package core_pkg;

    localparam int INST_W          = 34;
    localparam int INST_ADDR_W     = 11;

    localparam int INST_ACC        = 33;
    localparam int INST_CEN_PMEM   = 32;
    localparam int INST_WEN_PMEM   = 31;
    localparam int INST_A_PMEM_LSB = 20;
    localparam int INST_CEN_XMEM   = 19;
    localparam int INST_WEN_XMEM   = 18;
    localparam int INST_A_XMEM_LSB = 7;
    localparam int INST_OFIFO_RD   = 6;
    localparam int INST_IFIFO_WR   = 5;
    localparam int INST_IFIFO_RD   = 4;
    localparam int INST_L0_RD      = 3;
    localparam int INST_L0_WR      = 2;
    localparam int INST_EXECUTE    = 1;
    localparam int INST_LOAD       = 0;

    // Both SRAM chip enables and write enables deasserted (active low).
    localparam logic [INST_W-1:0] IDLE_WORD = 34'h1_800C_0000;

    typedef enum logic [2:0] {
        IDLE,
        W_L0,
        W_PE,
        GAP,
        A_L0,
        EXEC,
        DRAIN
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/xmem_to_l0.sv
// ---------------------------------------------------------------------------
// xmem_to_l0
// Streams `len` consecutive xmem words starting at `base` into the L0 buffer.
// While `en` is high the internal counter walks 0..len: a read is requested
// for counts 0..len-1, and l0_wr follows one count behind to cover the
// single-cycle SRAM read latency. `last` flags count == len, the cycle in
// which the final l0_wr is issued. Dropping `en` rewinds the counter.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   en          stream active
//   base        first xmem address
//   len         number of words to move
//   rd          xmem read request for this cycle
//   addr        xmem address for this cycle
//   l0_wr       L0 write strobe (data from the previous cycle's read)
//   last        final cycle of the stream
// ---------------------------------------------------------------------------
module xmem_to_l0 #(
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  len,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic              l0_wr,
    output logic              last
);

    logic [CNT_W-1:0] cnt;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign rd    = en && (cnt < len);
    assign addr  = base + ADDR_W'(cnt);
    assign l0_wr = en && (cnt != '0);
    assign last  = en && (cnt == len);

endmodule

// File: rtl/core_ctrl.sv
// ---------------------------------------------------------------------------
// core_ctrl
// Instruction sequencer for one full conv layer. For each of NKIJ kernel
// positions it loads COL weight words into L0, pushes them into the PE array,
// waits for the weights to settle, streams N_ACT activation words through
// L0, executes, and drains N_ACT psum vectors from the output FIFO into pmem.
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   start        one-cycle run request, honoured only when idle
//   ofifo_valid  core output FIFO holds a full psum vector
//   inst         registered 34-bit core instruction word
//   busy         high whenever the sequencer is not idle
//   done         one-cycle pulse alongside the final pmem write of the run
// ---------------------------------------------------------------------------
module core_ctrl
    import core_pkg::*;
#(
    parameter int ROW    = 8,
    parameter int COL    = 8,
    parameter int N_ACT  = 36,
    parameter int NKIJ   = 9,
    parameter int ADDR_W = 11,
    parameter int W_BASE = 0,
    parameter int A_BASE = 1024,
    parameter int P_BASE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(max2(COL, N_ACT) + 1);
    localparam int W_W   = $clog2(N_ACT + 1);
    localparam int K_W   = (NKIJ > 1) ? $clog2(NKIJ) : 1;
    localparam int CYC_W = $clog2(max2(max2(COL, ROW + COL), N_ACT) + 1);

    state_t             state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [W_W-1:0]     w_q, w_d;      // pmem writes done this kernel
    logic [W_W-1:0]     rd_q, rd_d;    // ofifo reads issued this kernel
    logic               pend_q, pend_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [INST_W-1:0]  inst_d;
    logic               done_d;

    logic               ld_en;
    logic [ADDR_W-1:0]  ld_base;
    logic [CNT_W-1:0]   ld_len;
    logic               ld_rd;
    logic [ADDR_W-1:0]  ld_addr;
    logic               ld_wr;
    logic               ld_last;

    // One loader serves both weight and activation fetches.
    assign ld_en   = (state_q == W_L0) || (state_q == A_L0);
    assign ld_base = (state_q == A_L0) ? ADDR_W'(A_BASE)
                                       : ADDR_W'(W_BASE) + ADDR_W'(k_q) * ADDR_W'(COL);
    assign ld_len  = (state_q == A_L0) ? CNT_W'(N_ACT) : CNT_W'(COL);

    xmem_to_l0 #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_xmem_to_l0 (
        .clk   (clk),
        .reset (reset),
        .en    (ld_en),
        .base  (ld_base),
        .len   (ld_len),
        .rd    (ld_rd),
        .addr  (ld_addr),
        .l0_wr (ld_wr),
        .last  (ld_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            w_q     <= '0;
            rd_q    <= '0;
            pend_q  <= 1'b0;
            cyc_q   <= '0;
            inst    <= IDLE_WORD;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            w_q     <= w_d;
            rd_q    <= rd_d;
            pend_q  <= pend_d;
            cyc_q   <= cyc_d;
            inst    <= inst_d;
            busy    <= (state_d != IDLE);
            done    <= done_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        w_d     = w_q;
        rd_d    = rd_q;
        pend_d  = 1'b0;
        cyc_d   = cyc_q;
        inst_d  = IDLE_WORD;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = W_L0;
                    k_d     = '0;
                end
            end
            W_L0, A_L0: begin
                inst_d[INST_CEN_XMEM] = ~ld_rd;
                if (ld_rd) inst_d[INST_A_XMEM_LSB +: ADDR_W] = ld_addr;
                inst_d[INST_L0_WR] = ld_wr;
                if (ld_last) begin
                    state_d = (state_q == W_L0) ? W_PE : EXEC;
                    cyc_d   = '0;
                end
            end
            W_PE: begin
                inst_d[INST_L0_RD] = 1'b1;
                inst_d[INST_LOAD]  = 1'b1;
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == CYC_W'(COL - 1)) begin
                    state_d = GAP;
                    cyc_d   = '0;
                end
            end
            GAP: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == CYC_W'(ROW + COL - 1)) begin
                    state_d = A_L0;
                    cyc_d   = '0;
                end
            end
            EXEC: begin
                inst_d[INST_L0_RD]   = 1'b1;
                inst_d[INST_EXECUTE] = 1'b1;
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == CYC_W'(N_ACT - 1)) begin
                    state_d = DRAIN;
                    cyc_d   = '0;
                    w_d     = '0;
                    rd_d    = '0;
                end
            end
            DRAIN: begin
                // A read and the write of the previously read vector may share a cycle.
                if (ofifo_valid && (rd_q < W_W'(N_ACT))) begin
                    inst_d[INST_OFIFO_RD] = 1'b1;
                    rd_d   = rd_q + 1'b1;
                    pend_d = 1'b1;
                end
                if (pend_q) begin
                    inst_d[INST_CEN_PMEM] = 1'b0;
                    inst_d[INST_WEN_PMEM] = 1'b0;
                    inst_d[INST_A_PMEM_LSB +: ADDR_W] =
                        ADDR_W'(P_BASE) + ADDR_W'(k_q) * ADDR_W'(N_ACT) + ADDR_W'(w_q);
                    w_d = w_q + 1'b1;
                    if (w_q == W_W'(N_ACT - 1)) begin
                        if (k_q == K_W'(NKIJ - 1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = W_L0;
                            k_d     = k_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Fields the sequencer never drives away from their idle value.
        inst_d[INST_ACC]      = 1'b0;
        inst_d[INST_IFIFO_WR] = 1'b0;
        inst_d[INST_IFIFO_RD] = 1'b0;
        inst_d[INST_WEN_XMEM] = 1'b1;
    end

endmodule
